// File: rtl/bp_sched.sv
// Backprop phase scheduler: sequences the delta / dx / dout phases of a
// two-layer recurrent pass from the last timestep down to the first.
module bp_sched #(
  parameter int TIMESTEP   = 7,
  parameter int LAYR1_CELL = 53,
  parameter int LAYR2_CELL = 8,
  parameter int DELTA_TIME = 12,
  parameter int DWU_DELAY  = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stall,
  input  logic       abort,
  output logic       en_delta,
  output logic       en_dx2,
  output logic       en_dout_2,
  output logic       en_delta1,
  output logic       en_dout_1,
  output logic       rst_mac_2,
  output logic       rst_mac_1,
  output logic [2:0] t_idx,
  output logic       busy,
  output logic       done
);

  localparam int LEN_D2  = LAYR2_CELL * DELTA_TIME;
  localparam int LEN_DX2 = 4 * LAYR2_CELL * LAYR2_CELL + DWU_DELAY;
  localparam int LEN_DO2 = 4 * LAYR2_CELL * LAYR1_CELL + DWU_DELAY;
  localparam int LEN_D1  = LAYR1_CELL * DELTA_TIME;
  localparam int LEN_DO1 = 4 * LAYR1_CELL * LAYR1_CELL + DWU_DELAY;

  localparam logic [CNT_WIDTH-1:0] LAST_D2  = CNT_WIDTH'(LEN_D2 - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_DX2 = CNT_WIDTH'(LEN_DX2 - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_DO2 = CNT_WIDTH'(LEN_DO2 - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_D1  = CNT_WIDTH'(LEN_D1 - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_DO1 = CNT_WIDTH'(LEN_DO1 - 1);

  typedef enum logic [2:0] {
    IDLE, D2, DX2, DO2, D1, DO1, FIN
  } state_t;

  state_t               state, nxt;
  logic [CNT_WIDTH-1:0] cnt, ncnt, last;
  logic [2:0]           t, nt;
  logic                 live;
  logic                 tail;

  assign tail  = (t == 3'd0);
  assign t_idx = t;

  always_comb begin
    last = '0;
    case (state)
      D2:      last = LAST_D2;
      DX2:     last = LAST_DX2;
      DO2:     last = LAST_DO2;
      D1:      last = LAST_D1;
      DO1:     last = LAST_DO1;
      default: last = '0;
    endcase
  end

  // live marks an edge that moves the schedule forward (not stalled)
  always_comb begin
    nxt  = state;
    ncnt = cnt;
    nt   = t;
    live = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          nxt  = D2;
          nt   = 3'(TIMESTEP - 1);
          ncnt = '0;
          live = 1'b1;
        end
      end
      FIN: nxt = IDLE;
      default: begin
        if (!stall) begin
          live = 1'b1;
          if (cnt == last) begin
            ncnt = '0;
            case (state)
              D2:  nxt = DX2;
              DX2: nxt = tail ? D1 : DO2;
              DO2: nxt = D1;
              D1:  nxt = tail ? FIN : DO1;
              DO1: begin
                nxt = D2;
                nt  = t - 3'd1;
              end
              default: nxt = IDLE;
            endcase
          end else begin
            ncnt = cnt + CNT_WIDTH'(1);
          end
        end
      end
    endcase
    if (abort && state != IDLE) begin
      nxt  = IDLE;
      ncnt = '0;
      nt   = '0;
      live = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      t         <= '0;
      en_delta  <= 1'b0;
      en_dx2    <= 1'b0;
      en_dout_2 <= 1'b0;
      en_delta1 <= 1'b0;
      en_dout_1 <= 1'b0;
      rst_mac_2 <= 1'b0;
      rst_mac_1 <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= nxt;
      cnt       <= ncnt;
      t         <= nt;
      en_delta  <= live && nxt == D2;
      en_dx2    <= live && nxt == DX2;
      en_dout_2 <= live && nxt == DO2;
      en_delta1 <= live && nxt == D1;
      en_dout_1 <= live && nxt == DO1;
      rst_mac_2 <= live && nxt != state
                   && (nxt == DX2 || nxt == DO2);
      rst_mac_1 <= live && nxt == DO1 && state != DO1;
      busy      <= nxt != IDLE;
      done      <= nxt == FIN;
    end
  end

endmodule

// File: tb/tb_bp_sched.sv
// Bench for bp_sched with shrunk parameters so a full pass is 94 cycles.
module tb_bp_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stall, abort;
  logic       en_delta, en_dx2, en_dout_2, en_delta1, en_dout_1;
  logic       rst_mac_2, rst_mac_1;
  logic [2:0] t_idx;
  logic       busy, done;

  always #5 clk = ~clk;

  // D2=3 DX2=5 DO2=9 D1=6 DO1=17 ; t=2,1 pass 40, t=0 pass 14
  bp_sched #(
    .TIMESTEP  (3),
    .LAYR1_CELL(2),
    .LAYR2_CELL(1),
    .DELTA_TIME(3),
    .DWU_DELAY (1),
    .CNT_WIDTH (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stall    (stall),
    .abort    (abort),
    .en_delta (en_delta),
    .en_dx2   (en_dx2),
    .en_dout_2(en_dout_2),
    .en_delta1(en_delta1),
    .en_dout_1(en_dout_1),
    .rst_mac_2(rst_mac_2),
    .rst_mac_1(rst_mac_1),
    .t_idx    (t_idx),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    logic [4:0] vec;
    logic [2:0] t;
    int         len;
  } seg_s;

  seg_s       exp_tab[13];
  logic [4:0] seg_vec[32];
  logic [2:0] seg_t[32];
  int         seg_len[32];
  int         nseg, m2, m1, first_en, done_at, gaps, multi;
  int         tests = 0;
  int         fails = 0;

  function automatic logic [4:0] en_vec();
    return {en_delta, en_dx2, en_dout_2, en_delta1, en_dout_1};
  endfunction

  function automatic logic [11:0] all_out();
    return {en_vec(), rst_mac_2, rst_mac_1, t_idx, busy, done};
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_seg(input int k, input logic [4:0] v,
                         input logic [2:0] tt, input int len);
    exp_tab[k].vec = v;
    exp_tab[k].t   = tt;
    exp_tab[k].len = len;
  endtask

  // Run one pass from IDLE, collecting phase segments until done.
  task automatic run_pass(input bit hold, input bit do_stall,
                          input bit poke);
    int         stall_left;
    bit         stalled_once;
    logic [4:0] v;
    nseg = 0; m2 = 0; m1 = 0; first_en = -1;
    done_at = -1; gaps = 0; multi = 0;
    stall_left = 0; stalled_once = 0;
    start = 1'b1;
    step();
    if (!hold) start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      v = en_vec();
      if (done) begin
        done_at = i;
        break;
      end
      if ($countones(v) > 1) multi++;
      if (rst_mac_2) m2++;
      if (rst_mac_1) m1++;
      if (v != 5'b0) begin
        if (first_en < 0) first_en = i;
        if (nseg == 0 || v != seg_vec[nseg-1]
            || t_idx != seg_t[nseg-1]) begin
          if (nseg < 32) begin
            seg_vec[nseg] = v;
            seg_t[nseg]   = t_idx;
            seg_len[nseg] = 0;
            nseg++;
          end
        end
        seg_len[nseg-1]++;
      end else if (first_en >= 0) begin
        gaps++;
      end
      if (do_stall && !stalled_once && v == 5'b01000
          && nseg == 2 && seg_len[1] == 2) begin
        stall_left   = 5;
        stalled_once = 1;
      end
      stall = (stall_left > 0);
      if (stall_left > 0) stall_left--;
      if (poke) start = (i % 5 == 2);
      step();
    end
    stall = 1'b0;
    if (poke) start = 1'b0;
  endtask

  task automatic check_pass(input string tag, input int extra);
    chk({tag, " nseg"}, 64'(nseg), 64'd13);
    for (int k = 0; k < 13; k++)
      chk($sformatf("%s seg%0d", tag, k),
          64'({seg_vec[k], seg_t[k], seg_len[k]}),
          64'({exp_tab[k].vec, exp_tab[k].t, exp_tab[k].len}));
    chk({tag, " first_en"}, 64'(first_en), 64'd0);
    chk({tag, " latency"}, 64'(done_at - first_en), 64'(94 + extra));
    chk({tag, " gaps"}, 64'(gaps), 64'(extra));
    chk({tag, " multi"}, 64'(multi), 64'd0);
    chk({tag, " mac2"}, 64'(m2), 64'd5);
    chk({tag, " mac1"}, 64'(m1), 64'd2);
  endtask

  initial begin
    bit found;
    for (int p = 0; p < 2; p++) begin
      set_seg(p*5 + 0, 5'b10000, 3'(2 - p), 3);
      set_seg(p*5 + 1, 5'b01000, 3'(2 - p), 5);
      set_seg(p*5 + 2, 5'b00100, 3'(2 - p), 9);
      set_seg(p*5 + 3, 5'b00010, 3'(2 - p), 6);
      set_seg(p*5 + 4, 5'b00001, 3'(2 - p), 17);
    end
    set_seg(10, 5'b10000, 3'd0, 3);
    set_seg(11, 5'b01000, 3'd0, 5);
    set_seg(12, 5'b00010, 3'd0, 6);

    rst = 1'b0; start = 1'b0; stall = 1'b0; abort = 1'b0;
    #23;
    chk("reset outs", 64'(all_out()), 64'd0);
    @(negedge clk) rst = 1'b1;
    step();
    chk("idle no start", 64'(all_out()), 64'd0);

    run_pass(0, 0, 0);
    check_pass("base", 0);
    step();
    chk("after fin", 64'(all_out()), 64'd0);

    run_pass(0, 1, 0);
    check_pass("stall", 5);
    step();

    run_pass(0, 0, 1);
    check_pass("poke", 0);
    step();

    run_pass(1, 0, 0);
    check_pass("hold", 0);
    step();
    chk("b2b idle", 64'(all_out()), 64'd0);
    step();
    chk("b2b restart", 64'({en_vec(), t_idx, busy}),
        64'({5'b10000, 3'd2, 1'b1}));
    start = 1'b0;

    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (en_dout_2 && t_idx == 3'd1) begin
        found = 1;
        break;
      end
      step();
    end
    chk("reach do2 t1", 64'(found), 64'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort outs", 64'(all_out()), 64'd0);
    for (int i = 0; i < 3; i++) step();
    chk("abort stays idle", 64'({busy, done}), 64'd0);
    run_pass(0, 0, 0);
    check_pass("post-abort", 0);
    step();

    start = 1'b1;
    step();
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (en_delta1) begin
        found = 1;
        break;
      end
      step();
    end
    chk("reach d1", 64'(found), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("async reset", 64'(all_out()), 64'd0);
    @(negedge clk) rst = 1'b1;
    step();
    chk("post-rst idle", 64'(all_out()), 64'd0);
    run_pass(0, 0, 0);
    check_pass("post-rst", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
